// File: rtl/bp_cce_lce_req_ingress.sv
// bp_cce_lce_req_ingress
//   CCE-side sink of the LCE request port. Accepts BedRock LCE request
//   messages over a ready-then-valid port, validates them, decodes each into
//   flat fields and buffers the decoded form in order. The CCE engine drains
//   the buffer head with a valid->yumi handshake. Malformed messages are
//   dropped and flagged; accepted requests are counted per request type.
//
//   Header layout (LSB first):
//     [3:0] msg_type, [6:4] size, addr, dst_id, src_id, non_exclusive, lru_way_id
//
// Ports
//   clk_i, reset_i         clock, asynchronous active-high reset
//   cce_id_i               this CCE's id, matched against header dst_id
//   lce_req_header_i       BedRock LCE request header
//   lce_req_data_i         request data, only [63:0] carries the uc_wr payload
//   lce_req_v_i            message valid (only while lce_req_ready_then_o=1)
//   lce_req_ready_then_o   buffer can absorb one message this cycle
//   req_v_o / req_yumi_i   decoded head available / consumed
//   req_type_o .. req_data_o   decoded head fields (zero when not applicable)
//   err_v_o, err_sticky_o  one-cycle drop pulse, sticky drop flag
//   stat_cnt_o             saturating accepted count per type, type t at [t*stat_width_p +: stat_width_p]
module bp_cce_lce_req_ingress #(
  parameter int unsigned paddr_width_p     = 40,
  parameter int unsigned lce_id_width_p    = 4,
  parameter int unsigned cce_id_width_p    = 4,
  parameter int unsigned lce_assoc_p       = 8,
  parameter int unsigned cce_block_width_p = 512,
  parameter int unsigned els_p             = 2,
  parameter int unsigned stat_width_p      = 16,
  localparam int unsigned lg_assoc_lp      = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1,
  localparam int unsigned lce_req_header_width_lp =
    4 + 3 + paddr_width_p + cce_id_width_p + lce_id_width_p + 1 + lg_assoc_lp
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [cce_id_width_p-1:0]          cce_id_i,
  input  logic [lce_req_header_width_lp-1:0] lce_req_header_i,
  input  logic [cce_block_width_p-1:0]       lce_req_data_i,
  input  logic                               lce_req_v_i,
  output logic                               lce_req_ready_then_o,
  output logic                               req_v_o,
  input  logic                               req_yumi_i,
  output logic [1:0]                         req_type_o,
  output logic [paddr_width_p-1:0]           req_addr_o,
  output logic [lce_id_width_p-1:0]          req_lce_id_o,
  output logic [lg_assoc_lp-1:0]             req_lru_way_o,
  output logic                               req_non_excl_o,
  output logic [2:0]                         req_size_o,
  output logic [63:0]                        req_data_o,
  output logic                               err_v_o,
  output logic                               err_sticky_o,
  output logic [4*stat_width_p-1:0]          stat_cnt_o
);

  localparam int unsigned size_lsb_lp = 4;
  localparam int unsigned addr_lsb_lp = 7;
  localparam int unsigned dst_lsb_lp  = addr_lsb_lp + paddr_width_p;
  localparam int unsigned src_lsb_lp  = dst_lsb_lp + cce_id_width_p;
  localparam int unsigned nx_lsb_lp   = src_lsb_lp + lce_id_width_p;
  localparam int unsigned lru_lsb_lp  = nx_lsb_lp + 1;
  localparam int unsigned ptr_w_lp    = $clog2(els_p);
  localparam int unsigned occ_w_lp    = $clog2(els_p + 1);

  typedef enum logic {e_reset, e_ready} state_e;

  typedef struct packed {
    logic [1:0]                typ;
    logic [paddr_width_p-1:0]  addr;
    logic [lce_id_width_p-1:0] lce_id;
    logic [lg_assoc_lp-1:0]    lru;
    logic                      non_excl;
    logic [2:0]                size;
    logic [63:0]               data;
  } entry_s;

  state_e state, state_next;
  entry_s mem [els_p];
  entry_s dec, head;
  logic [ptr_w_lp-1:0] wptr, rptr;
  logic [occ_w_lp-1:0] occ;
  logic [stat_width_p-1:0] cnt [4];
  logic [3:0] msg_type;
  logic [2:0] msg_size;
  logic msg_ok, accept, push, pop;

  // upper data bits carry no information for this sink
  logic unused_data;
  assign unused_data = ^lce_req_data_i[cce_block_width_p-1:64];

  always_comb begin
    state_next = state;
    if (state == e_reset) state_next = e_ready;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= e_reset;
    else         state <= state_next;
  end

  // Decode and validate; fields that do not apply to the type are zeroed
  always_comb begin
    msg_type     = lce_req_header_i[3:0];
    msg_size     = lce_req_header_i[size_lsb_lp +: 3];
    msg_ok       = (msg_type[3:2] == 2'b00)
                 && (lce_req_header_i[dst_lsb_lp +: cce_id_width_p] == cce_id_i)
                 && !(msg_type[1] && (msg_size > 3'd3));
    dec          = '0;
    dec.typ      = msg_type[1:0];
    dec.addr     = lce_req_header_i[addr_lsb_lp +: paddr_width_p];
    dec.lce_id   = lce_req_header_i[src_lsb_lp +: lce_id_width_p];
    dec.size     = msg_size;
    if (!msg_type[1])            dec.lru      = lce_req_header_i[lru_lsb_lp +: lg_assoc_lp];
    if (msg_type[1:0] == 2'b00)  dec.non_excl = lce_req_header_i[nx_lsb_lp];
    if (msg_type[1:0] == 2'b11)  dec.data     = lce_req_data_i[63:0];
  end

  assign lce_req_ready_then_o = (state == e_ready) && (occ < occ_w_lp'(els_p));
  assign req_v_o = (occ != '0);
  assign accept  = lce_req_v_i && lce_req_ready_then_o;
  assign push    = accept && msg_ok;
  assign pop     = req_yumi_i && req_v_o;

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= dec;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr         <= '0;
      rptr         <= '0;
      occ          <= '0;
      err_v_o      <= 1'b0;
      err_sticky_o <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      if (push) begin
        wptr <= (wptr == ptr_w_lp'(els_p - 1)) ? '0 : wptr + 1'b1;
        if (cnt[dec.typ] != '1) cnt[dec.typ] <= cnt[dec.typ] + 1'b1;
      end
      if (pop) rptr <= (rptr == ptr_w_lp'(els_p - 1)) ? '0 : rptr + 1'b1;
      if (push && !pop)      occ <= occ + 1'b1;
      else if (pop && !push) occ <= occ - 1'b1;
      err_v_o <= accept && !msg_ok;
      if (accept && !msg_ok) err_sticky_o <= 1'b1;
    end
  end

  // Head fields are masked when empty so stale storage never reaches the outputs
  always_comb begin
    head           = req_v_o ? mem[rptr] : '0;
    req_type_o     = head.typ;
    req_addr_o     = head.addr;
    req_lce_id_o   = head.lce_id;
    req_lru_way_o  = head.lru;
    req_non_excl_o = head.non_excl;
    req_size_o     = head.size;
    req_data_o     = head.data;
  end

  always_comb begin
    stat_cnt_o = '0;
    for (int unsigned i = 0; i < 4; i++)
      stat_cnt_o[i*stat_width_p +: stat_width_p] = cnt[i];
  end

  a_v_needs_ready: assert property (@(posedge clk_i) disable iff (reset_i)
    lce_req_v_i |-> lce_req_ready_then_o);
  a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (reset_i)
    req_yumi_i |-> req_v_o);

endmodule

// File: tb/tb_bp_cce_lce_req_ingress.sv
// Testbench for bp_cce_lce_req_ingress: scoreboard of decoded requests,
// pushed when a valid message is driven, popped when the CCE side consumes.
module tb_bp_cce_lce_req_ingress;
  localparam int unsigned PA = 40, LID = 4, CID = 4, ASSOC = 8, BLK = 512;
  localparam int unsigned ELS = 2, SW = 3, LG = 3;
  localparam int unsigned HW = 4 + 3 + PA + CID + LID + 1 + LG;

  logic clk = 1'b0;
  logic reset_i;
  logic [CID-1:0] cce_id;
  logic [HW-1:0] hdr;
  logic [BLK-1:0] data;
  logic v, ready_then, req_v, yumi, req_nx, err_v, err_sticky;
  logic [1:0] req_type;
  logic [PA-1:0] req_addr;
  logic [LID-1:0] req_lce;
  logic [LG-1:0] req_lru;
  logic [2:0] req_size;
  logic [63:0] req_data;
  logic [4*SW-1:0] stat;

  always #5 clk = ~clk;

  bp_cce_lce_req_ingress #(
    .paddr_width_p(PA), .lce_id_width_p(LID), .cce_id_width_p(CID),
    .lce_assoc_p(ASSOC), .cce_block_width_p(BLK), .els_p(ELS), .stat_width_p(SW)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .cce_id_i(cce_id),
    .lce_req_header_i(hdr), .lce_req_data_i(data), .lce_req_v_i(v),
    .lce_req_ready_then_o(ready_then), .req_v_o(req_v), .req_yumi_i(yumi),
    .req_type_o(req_type), .req_addr_o(req_addr), .req_lce_id_o(req_lce),
    .req_lru_way_o(req_lru), .req_non_excl_o(req_nx), .req_size_o(req_size),
    .req_data_o(req_data), .err_v_o(err_v), .err_sticky_o(err_sticky),
    .stat_cnt_o(stat)
  );

  typedef struct packed {
    logic [1:0] typ; logic [PA-1:0] addr; logic [LID-1:0] lce; logic [LG-1:0] lru;
    logic nx; logic [2:0] size; logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e, mon_a;
  logic [SW-1:0] exp_stat [4];
  int unsigned checks = 0, errors = 0;
  int unsigned errcnt;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [HW-1:0] mk_hdr(input logic [3:0] mt, input logic [2:0] sz,
      input logic [PA-1:0] a, input logic [CID-1:0] dst, input logic [LID-1:0] src,
      input logic nx, input logic [LG-1:0] lru);
    return {lru, nx, src, dst, a, sz, mt};
  endfunction

  function automatic logic [4*SW-1:0] stat_model();
    return {exp_stat[3], exp_stat[2], exp_stat[1], exp_stat[0]};
  endfunction

  task automatic step();
    @(posedge clk); #1;
    v = 1'b0;
    yumi = 1'b0;
  endtask

  // Drive one message this cycle; record expected decode when it should be accepted
  task automatic send(input logic [3:0] mt, input logic [2:0] sz, input logic [PA-1:0] a,
      input logic [CID-1:0] dst, input logic [LID-1:0] src, input logic nx,
      input logic [LG-1:0] lru, input logic [63:0] d);
    exp_t e;
    hdr = mk_hdr(mt, sz, a, dst, src, nx, lru);
    data = {16{$urandom()}};
    data[63:0] = d;
    v = 1'b1;
    if (mt < 4'd4 && dst == cce_id && !(mt >= 4'd2 && sz > 3'd3)) begin
      e.typ  = mt[1:0];
      e.addr = a;
      e.lce  = src;
      e.lru  = (mt < 4'd2) ? lru : '0;
      e.nx   = (mt == 4'd0) ? nx : 1'b0;
      e.size = sz;
      e.data = (mt == 4'd3) ? d : 64'd0;
      sb.push_back(e);
      if (exp_stat[mt[1:0]] != '1) exp_stat[mt[1:0]] = exp_stat[mt[1:0]] + 1'b1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && req_v; i++) begin
      yumi = 1'b1;
      @(negedge clk);
      step();
    end
    check("drained", req_v, 1'b0);
    check("sb_left", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!reset_i && yumi && req_v) begin
      if (sb.size() == 0) begin
        check("sb_empty", sb.size(), 1);
      end else begin
        mon_e = sb.pop_front();
        mon_a = {req_type, req_addr, req_lce, req_lru, req_nx, req_size, req_data};
        check("pop", mon_a, mon_e);
      end
    end
  end

  initial begin
    reset_i = 1'b1; cce_id = 4'd5; hdr = '0; data = '0; v = 1'b0; yumi = 1'b0;
    for (int i = 0; i < 4; i++) exp_stat[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", ready_then, 1'b0);
    check("rst_req_v", req_v, 1'b0);
    check("rst_err", {err_v, err_sticky}, 2'b00);
    check("rst_stat", stat, stat_model());
    @(posedge clk); #1 reset_i = 1'b0;
    @(negedge clk);
    check("ready_in_e_reset", ready_then, 1'b0);
    step();
    @(negedge clk);
    check("ready_after_reset", ready_then, 1'b1);
    step();

    // rd_miss decode
    send(4'd0, 3'd6, 40'h80000040, cce_id, 4'd2, 1'b1, 3'd3, 64'h1234);
    @(negedge clk);
    check("no_cut_through", req_v, 1'b0);
    step();
    @(negedge clk);
    check("t1_v", req_v, 1'b1);
    check("t1_type", req_type, 2'd0);
    check("t1_addr", req_addr, 40'h80000040);
    check("t1_lce", req_lce, 4'd2);
    check("t1_lru_nx", {req_lru, req_nx}, {3'd3, 1'b1});
    check("t1_data", req_data, 64'd0);
    check("t1_stat", stat, stat_model());
    step();
    drain();

    // uc_wr decode with cached-only fields forced to zero
    send(4'd3, 3'd3, 40'h00001000, cce_id, 4'd7, 1'b1, 3'd5, 64'hDEADBEEF01234567);
    step();
    @(negedge clk);
    check("t2_type", req_type, 2'd3);
    check("t2_data", req_data, 64'hDEADBEEF01234567);
    check("t2_lru_nx", {req_lru, req_nx}, 4'd0);
    step();
    drain();

    // fill to capacity, no bypass on pop, order A,B,C
    send(4'd0, 3'd6, 40'hA0, cce_id, 4'd1, 1'b0, 3'd1, 64'd0);
    step();
    send(4'd1, 3'd6, 40'hB0, cce_id, 4'd2, 1'b1, 3'd2, 64'd0);
    step();
    @(negedge clk);
    check("full_ready", ready_then, 1'b0);
    step();
    yumi = 1'b1;
    @(negedge clk);
    check("no_bypass", ready_then, 1'b0);
    step();
    send(4'd0, 3'd6, 40'hC0, cce_id, 4'd3, 1'b1, 3'd7, 64'd0);
    @(negedge clk);
    check("ready_after_pop", ready_then, 1'b1);
    step();
    drain();

    // malformed messages: wrong dst, uc_amo, oversized uc_rd
    errcnt = 0;
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: send(4'd0, 3'd6, 40'h100, cce_id + 4'd1, 4'd1, 1'b0, 3'd0, 64'd0);
        1: send(4'd4, 3'd3, 40'h200, cce_id, 4'd1, 1'b0, 3'd0, 64'd0);
        2: send(4'd2, 3'd4, 40'h300, cce_id, 4'd1, 1'b0, 3'd0, 64'd0);
        default: ;
      endcase
      @(negedge clk);
      if (err_v) errcnt++;
      step();
    end
    check("t4_err_pulses", errcnt, 3);
    check("t4_req_v", req_v, 1'b0);
    check("t4_sticky", err_sticky, 1'b1);
    check("t4_stat", stat, stat_model());

    // steady push+pop at occupancy 1; rd_miss count reaches saturation
    send(4'd0, 3'd6, 40'h1000, cce_id, 4'd0, 1'b1, 3'd0, 64'd0);
    step();
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) send(4'd0, 3'd6, 40'h2000 + 40'(i), cce_id, 4'(i), 1'b1, 3'(i), 64'd0);
      else            send(4'd3, 3'd3, 40'h3000 + 40'(i), cce_id, 4'(i), 1'b0, 3'd0, 64'(i * 1000 + 7));
      yumi = 1'b1;
      @(negedge clk);
      check("t5_occ1", {req_v, ready_then}, 2'b11);
      step();
    end
    drain();
    check("t5_stat_sat", stat, stat_model());

    // asynchronous reset with two buffered entries
    send(4'd1, 3'd6, 40'h4000, cce_id, 4'd1, 1'b0, 3'd1, 64'd0);
    step();
    send(4'd2, 3'd2, 40'h5000, cce_id, 4'd2, 1'b0, 3'd0, 64'd0);
    step();
    @(negedge clk);
    check("t6_pre_v", req_v, 1'b1);
    #2 reset_i = 1'b1;
    #1;
    check("t6_req_v", req_v, 1'b0);
    check("t6_ready", ready_then, 1'b0);
    check("t6_stat", stat, '0);
    check("t6_sticky", err_sticky, 1'b0);
    sb.delete();
    for (int i = 0; i < 4; i++) exp_stat[i] = '0;
    @(posedge clk); #1 reset_i = 1'b0;
    @(negedge clk);
    check("t6_e_reset", ready_then, 1'b0);
    step();
    @(negedge clk);
    check("t6_e_ready", ready_then, 1'b1);
    check("t6_empty", req_v, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1);
  end
endmodule
